kong_motion_ctl: RTL and testbench
==================================

# kong_motion_ctl

Parametrised motion controller for the Kong character, the successor to the fixed constants in the kong package. It runs the intro climb from the initial position up to the platform, then handles walking and jumping. Step rates, jump height, start/platform coordinates and playfield bounds are all parameters. It sits between the input/game logic and the Kong sprite draw block and produces registered sprite coordinates every clock.

## Interface
- `JUMP_HEIGHT`, 58: jump apex offset in pixels above the base ypos.
- `JUMP_TICKS`, 1_400_000: clocks per 1-pixel vertical step while jumping.
- `MOVE_TICKS`, 250_000: clocks per 1-pixel step while climbing or walking.
- `INIT_XPOS`, 484: x coordinate after reset.
- `INIT_YPOS`, 672: y coordinate after reset.
- `PLATFORM_YPOS`, 175: y coordinate where the climb ends.
- `CHAR_W`, 48: sprite width.
- `CHAR_H`, 64: sprite height (passed through to `char_h`).
- `X_MIN`, 0: leftmost legal xpos.
- `X_MAX`, 1024-48: rightmost legal xpos.
- `POS_W`, 11: width of the coordinate outputs.
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: synchronous reset, active-high.
- `start` in 1: begins the intro climb; sampled only in IDLE.
- `left` in 1: level request to walk left.
- `right` in 1: level request to walk right.
- `jump` in 1: level request to jump; sampled only in WALK.
- `xpos` out POS_W: sprite left edge.
- `ypos` out POS_W: sprite top edge.
- `char_w` out POS_W: constant `CHAR_W`.
- `char_h` out POS_W: constant `CHAR_H`.
- `on_platform` out 1: high when in WALK, JUMP_UP or JUMP_DOWN.
- `airborne` out 1: high when in JUMP_UP or JUMP_DOWN.
- `climb_done` out 1: one-cycle pulse on the CLIMB→WALK transition.

## Operation
- States: IDLE, CLIMB, WALK, JUMP_UP, JUMP_DOWN.
- Reset (any state, any cycle): state=IDLE, xpos=INIT_XPOS, ypos=INIT_YPOS, base=PLATFORM_YPOS, all counters 0, all flags 0. A reset mid-jump or mid-climb wins unconditionally.
- IDLE:
  - `start`=1 → CLIMB; the move counter clears.
  - Left/right/jump are ignored.
- CLIMB:
  - Each move tick: ypos−1.
  - When ypos reaches PLATFORM_YPOS (the step that writes that value), the next state is WALK and `climb_done` pulses in that cycle.
  - If INIT_YPOS ≤ PLATFORM_YPOS, the block goes to WALK on the first tick.
- WALK:
  - On each move tick, `left` xor `right` steps xpos by 1, saturating at X_MIN/X_MAX.
  - Both or neither asserted: no move.
  - `jump`=1 → JUMP_UP, and the jump counter clears. base=ypos.
- JUMP_UP:
  - Each jump tick: ypos−1.
  - When ypos = base−JUMP_HEIGHT → JUMP_DOWN.
- JUMP_DOWN:
  - Each jump tick: ypos+1.
  - When ypos = base → WALK. `jump` still held re-enters JUMP_UP on the next WALK cycle (auto-repeat).
- Horizontal moves continue in JUMP_UP/JUMP_DOWN on the move tick with the same rules (air control).
- Tick generation: two independent counters.
  - Move counter: 0..MOVE_TICKS−1. Tick is the cycle it equals MOVE_TICKS−1, then it wraps to 0. It free-runs in CLIMB/WALK/JUMP_*.
  - Jump counter: 0..JUMP_TICKS−1, same rule, running only in JUMP_*.
  - Counter widths are $clog2 of each TICKS parameter (minimum 1).
- Coordinate arithmetic is unsigned POS_W. base−JUMP_HEIGHT must not underflow; this is a parameter-legality requirement, checked by an elaboration assertion: PLATFORM_YPOS ≥ JUMP_HEIGHT.

## Timing
- All outputs are registered.
- Position changes are visible the cycle after the tick cycle.
- `start` to CLIMB: 1 cycle. The first climb step lands MOVE_TICKS cycles after entering CLIMB.
- Climb duration: (INIT_YPOS−PLATFORM_YPOS)·MOVE_TICKS cycles.
- Full jump: 2·JUMP_HEIGHT·JUMP_TICKS cycles from JUMP_UP entry to WALK re-entry.
- Move tick and jump tick in the same cycle: both updates apply in that cycle (x and y are independent).
- `climb_done` is high for exactly one cycle. It is 0 during reset.

## Test plan
Run with MOVE_TICKS=2, JUMP_TICKS=3, INIT_YPOS=20, PLATFORM_YPOS=15, JUMP_HEIGHT=4, X_MIN=0, X_MAX=10, INIT_XPOS=9.
- Reset, then `start` pulse:
  - ypos steps 20→15, one step every 2 cycles.
  - `climb_done` is a single pulse and `on_platform` rises.
  - xpos stays 9 throughout.
- In WALK, hold `right` for 10 cycles → xpos reaches 10 and saturates. Hold `left`+`right` → xpos stays constant.
- In WALK, `jump` 1-cycle pulse:
  - ypos goes 15→11, one step every 3 cycles, then back to 15.
  - `airborne` is high for 24 cycles, then state is WALK.
- Hold `jump` together with `left` → jumps repeat back-to-back while xpos decrements every 2 cycles down to 0.
- Assert `rst` mid-JUMP_UP (ypos=13) → the next cycle shows xpos=9, ypos=20, IDLE, all flags 0.
- In IDLE, assert `left`/`jump` without `start` → no change for 50 cycles.

Source files
------------

// File: rtl/kong_motion_ctl.sv
// rtl/kong_motion_ctl.sv - Kong sprite motion controller: intro climb, walk, jump
//
// Runs the intro climb from (INIT_XPOS, INIT_YPOS) up to PLATFORM_YPOS, then
// handles walking left/right and jumping with air control. All sprite outputs
// are registered.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin intro climb (sampled only in IDLE)
//   left, right       : level walk requests (opposing requests cancel)
//   jump              : level jump request (sampled only in WALK)
//   xpos, ypos        : sprite top-left corner
//   char_w, char_h    : constant sprite size
//   on_platform       : in WALK / JUMP_UP / JUMP_DOWN
//   airborne          : in JUMP_UP / JUMP_DOWN
//   climb_done        : one-cycle pulse on arrival at the platform

module kong_motion_ctl #(
    parameter int JUMP_HEIGHT   = 58,
    parameter int JUMP_TICKS    = 1_400_000,
    parameter int MOVE_TICKS    = 250_000,
    parameter int INIT_XPOS     = 484,
    parameter int INIT_YPOS     = 672,
    parameter int PLATFORM_YPOS = 175,
    parameter int CHAR_W        = 48,
    parameter int CHAR_H        = 64,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 1024 - 48,
    parameter int POS_W         = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             left,
    input  logic             right,
    input  logic             jump,
    output logic [POS_W-1:0] xpos,
    output logic [POS_W-1:0] ypos,
    output logic [POS_W-1:0] char_w,
    output logic [POS_W-1:0] char_h,
    output logic             on_platform,
    output logic             airborne,
    output logic             climb_done
);

    localparam int MCW = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
    localparam int JCW = (JUMP_TICKS > 1) ? $clog2(JUMP_TICKS) : 1;

    localparam logic [MCW-1:0]   MOVE_LAST = MCW'(MOVE_TICKS - 1);
    localparam logic [JCW-1:0]   JUMP_LAST = JCW'(JUMP_TICKS - 1);
    localparam logic [POS_W-1:0] X_MIN_P   = POS_W'(X_MIN);
    localparam logic [POS_W-1:0] X_MAX_P   = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] INIT_X_P  = POS_W'(INIT_XPOS);
    localparam logic [POS_W-1:0] INIT_Y_P  = POS_W'(INIT_YPOS);
    localparam logic [POS_W-1:0] PLAT_P    = POS_W'(PLATFORM_YPOS);
    localparam logic [POS_W-1:0] HEIGHT_P  = POS_W'(JUMP_HEIGHT);
    localparam logic [POS_W-1:0] ONE_P     = POS_W'(1);

    // The jump apex is base - JUMP_HEIGHT in unsigned arithmetic; base starts
    // at the platform, so the platform must sit at least one jump below 0.
    if (PLATFORM_YPOS < JUMP_HEIGHT) begin : g_bad_params
        $error("kong_motion_ctl: PLATFORM_YPOS must be >= JUMP_HEIGHT");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLIMB,
        S_WALK,
        S_JUMP_UP,
        S_JUMP_DOWN
    } state_t;

    state_t           state_q, state_d;
    logic [MCW-1:0]   mcnt_q, mcnt_d;
    logic [JCW-1:0]   jcnt_q, jcnt_d;
    logic [POS_W-1:0] xpos_q, xpos_d;
    logic [POS_W-1:0] ypos_q, ypos_d;
    logic [POS_W-1:0] base_q, base_d;
    logic             on_platform_q, on_platform_d;
    logic             airborne_q, airborne_d;
    logic             climb_done_q, climb_done_d;

    logic             in_jump;
    logic             move_tick;
    logic             jump_tick;
    logic             climb_arrive;
    logic [POS_W-1:0] apex;

    assign in_jump   = (state_q == S_JUMP_UP) || (state_q == S_JUMP_DOWN);
    assign move_tick = (state_q != S_IDLE) && (mcnt_q == MOVE_LAST);
    assign jump_tick = in_jump && (jcnt_q == JUMP_LAST);
    assign apex      = base_q - HEIGHT_P;

    // Arrival covers both the normal last step and a start position that is
    // already at or above the platform.
    assign climb_arrive = (ypos_q <= PLAT_P) || ((ypos_q - ONE_P) == PLAT_P);

    // State register (plus datapath flops)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mcnt_q        <= '0;
            jcnt_q        <= '0;
            xpos_q        <= INIT_X_P;
            ypos_q        <= INIT_Y_P;
            base_q        <= PLAT_P;
            on_platform_q <= 1'b0;
            airborne_q    <= 1'b0;
            climb_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            mcnt_q        <= mcnt_d;
            jcnt_q        <= jcnt_d;
            xpos_q        <= xpos_d;
            ypos_q        <= ypos_d;
            base_q        <= base_d;
            on_platform_q <= on_platform_d;
            airborne_q    <= airborne_d;
            climb_done_q  <= climb_done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start) state_d = S_CLIMB;
            S_CLIMB:     if (move_tick && climb_arrive) state_d = S_WALK;
            S_WALK:      if (jump) state_d = S_JUMP_UP;
            S_JUMP_UP:   if (jump_tick && ((ypos_q - ONE_P) == apex)) state_d = S_JUMP_DOWN;
            S_JUMP_DOWN: if (jump_tick && ((ypos_q + ONE_P) == base_q)) state_d = S_WALK;
            default:     state_d = S_IDLE;
        endcase
    end

    // Tick counters and coordinates
    always_comb begin
        mcnt_d = mcnt_q;
        jcnt_d = jcnt_q;
        xpos_d = xpos_q;
        ypos_d = ypos_q;
        base_d = base_q;

        // Move counter rests at 0 in IDLE, so entering CLIMB starts a full period.
        if (state_q == S_IDLE) begin
            mcnt_d = '0;
        end else if (move_tick) begin
            mcnt_d = '0;
        end else begin
            mcnt_d = mcnt_q + 1'b1;
        end

        // Jump counter rests at 0 outside the jump states, so each jump starts fresh.
        if (!in_jump || jump_tick) begin
            jcnt_d = '0;
        end else begin
            jcnt_d = jcnt_q + 1'b1;
        end

        // Horizontal movement, including air control during jumps.
        if (move_tick && ((state_q == S_WALK) || in_jump)) begin
            if (left && !right && (xpos_q > X_MIN_P)) begin
                xpos_d = xpos_q - ONE_P;
            end else if (right && !left && (xpos_q < X_MAX_P)) begin
                xpos_d = xpos_q + ONE_P;
            end
        end

        case (state_q)
            S_CLIMB: begin
                // A start position at/above the platform snaps onto it.
                if (move_tick) begin
                    ypos_d = (ypos_q <= PLAT_P) ? PLAT_P : (ypos_q - ONE_P);
                end
            end
            S_WALK: begin
                if (jump) base_d = ypos_q;
            end
            S_JUMP_UP: begin
                if (jump_tick) ypos_d = ypos_q - ONE_P;
            end
            S_JUMP_DOWN: begin
                if (jump_tick) ypos_d = ypos_q + ONE_P;
            end
            default: ;
        endcase
    end

    // Output logic: flags are computed from the next state so that the
    // registered copies line up with the registered state.
    always_comb begin
        on_platform_d = (state_d == S_WALK) || (state_d == S_JUMP_UP) || (state_d == S_JUMP_DOWN);
        airborne_d    = (state_d == S_JUMP_UP) || (state_d == S_JUMP_DOWN);
        climb_done_d  = (state_q == S_CLIMB) && (state_d == S_WALK);
    end

    assign xpos        = xpos_q;
    assign ypos        = ypos_q;
    assign char_w      = POS_W'(CHAR_W);
    assign char_h      = POS_W'(CHAR_H);
    assign on_platform = on_platform_q;
    assign airborne    = airborne_q;
    assign climb_done  = climb_done_q;

endmodule

// File: tb/tb_kong_motion_ctl.sv
// tb/tb_kong_motion_ctl.sv - scoreboard bench for kong_motion_ctl

module tb_kong_motion_ctl;

    localparam int POS_W = 11;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             left;
    logic             right;
    logic             jump;
    logic [POS_W-1:0] xpos;
    logic [POS_W-1:0] ypos;
    logic [POS_W-1:0] char_w;
    logic [POS_W-1:0] char_h;
    logic             on_platform;
    logic             airborne;
    logic             climb_done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int x;
        int y;
        int on;
        int air;
        int cd;
    } exp_t;

    exp_t sb[$];

    kong_motion_ctl #(
        .JUMP_HEIGHT   (4),
        .JUMP_TICKS    (3),
        .MOVE_TICKS    (2),
        .INIT_XPOS     (9),
        .INIT_YPOS     (20),
        .PLATFORM_YPOS (15),
        .CHAR_W        (48),
        .CHAR_H        (64),
        .X_MIN         (0),
        .X_MAX         (10),
        .POS_W         (POS_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .left        (left),
        .right       (right),
        .jump        (jump),
        .xpos        (xpos),
        .ypos        (ypos),
        .char_w      (char_w),
        .char_h      (char_h),
        .on_platform (on_platform),
        .airborne    (airborne),
        .climb_done  (climb_done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Push the expectation, advance one clock, then pop and compare the
    // registered outputs just after the edge.
    task automatic cycle(input string tag, input int ex, input int ey,
                         input int eon, input int eair, input int ecd);
        exp_t e;
        e.x = ex; e.y = ey; e.on = eon; e.air = eair; e.cd = ecd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_val({tag, ".xpos"},        32'(xpos),        32'(e.x));
        check_val({tag, ".ypos"},        32'(ypos),        32'(e.y));
        check_val({tag, ".on_platform"}, 32'(on_platform), 32'(e.on));
        check_val({tag, ".airborne"},    32'(airborne),    32'(e.air));
        check_val({tag, ".climb_done"},  32'(climb_done),  32'(e.cd));
    endtask

    // ypos k cycles after entering JUMP_UP from base 15 (height 4, 3 clocks/step).
    function automatic int jump_y(input int k);
        if (k <= 12)      return 15 - k / 3;
        else if (k <= 24) return 11 + (k - 12) / 3;
        else              return 15;
    endfunction

    initial begin
        int x;
        int k;
        rst = 1'b1; start = 1'b0; left = 1'b0; right = 1'b0; jump = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cycle("reset", 9, 20, 0, 0, 0);
        check_val("char_w", 32'(char_w), 32'd48);
        check_val("char_h", 32'(char_h), 32'd64);
        rst = 1'b0;
        cycle("idle", 9, 20, 0, 0, 0);

        // g counts clocks since CLIMB entry; the move counter free-runs from
        // there, so move ticks land on even g.
        start = 1'b1;
        cycle("start", 9, 20, 0, 0, 0);
        start = 1'b0;
        for (int g = 1; g <= 12; g++) begin
            cycle("climb", 9, (g <= 10) ? 20 - g / 2 : 15, (g >= 10) ? 1 : 0, 0, (g == 10) ? 1 : 0);
        end

        right = 1'b1;
        for (int g = 13; g <= 22; g++) begin
            cycle("walk_right", (g >= 14) ? 10 : 9, 15, 1, 0, 0);
        end
        left = 1'b1;
        for (int g = 23; g <= 28; g++) begin
            cycle("walk_both", 10, 15, 1, 0, 0);
        end
        left = 1'b0; right = 1'b0;

        // Single jump pulse, JUMP_UP entered at g=29.
        jump = 1'b1;
        cycle("jump", 10, jump_y(0), 1, 1, 0);
        jump = 1'b0;
        for (k = 1; k <= 26; k++) begin
            cycle("jump", 10, jump_y(k), 1, (k < 24) ? 1 : 0, 0);
        end

        // Held jump + left: jumps repeat with a 25-cycle period starting g=56.
        jump = 1'b1; left = 1'b1;
        for (int g = 56; g <= 112; g++) begin
            k = (g - 56) % 25;
            x = 10 - (g - 54) / 2;
            if (x < 0) x = 0;
            cycle("jump_left", x, jump_y(k), 1, (k < 24) ? 1 : 0, 0);
        end
        check_val("mid_jump_ypos", 32'(ypos), 32'd13);

        rst = 1'b1; jump = 1'b0; left = 1'b0;
        cycle("reset_mid_jump", 9, 20, 0, 0, 0);
        rst = 1'b0;

        left = 1'b1; jump = 1'b1;
        repeat (50) cycle("idle_ignore", 9, 20, 0, 0, 0);
        left = 1'b0; jump = 1'b0;

        check_val("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
